// File: rtl/cnn_pkg.sv
// Shared helpers for the CNN accelerator datapath: output-dimension and tap-index
// arithmetic plus the default packed pixel type.
package cnn_pkg;

  localparam int PIX_DATA_W = 8;
  localparam int PIX_CH     = 1;

  typedef logic [PIX_CH*PIX_DATA_W-1:0] pix_t;

  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

  function automatic int tap_idx(input int m, input int n, input int k);
    return m * k + n;
  endfunction

endpackage

// File: rtl/im2col_line_buf.sv
// K-1 buffered image rows. Accepting a pixel shifts its column up by one row,
// so row 0 always holds the oldest buffered image row.
module im2col_line_buf
  import cnn_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ROWS  = 2,
  parameter int IMG_W = 28,
  parameter int CW    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_en,
  input  logic [CW-1:0]         col,
  input  logic [PIX_W-1:0]      pix_in,
  output logic [ROWS*PIX_W-1:0] col_out
);

  logic [PIX_W-1:0] mem [ROWS][IMG_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < ROWS; j++)
        for (int x = 0; x < IMG_W; x++)
          mem[j][x] <= '0;
    end else if (shift_en) begin
      for (int j = 0; j < ROWS-1; j++)
        mem[j][col] <= mem[j+1][col];
      mem[ROWS-1][col] <= pix_in;
    end
  end

  // Read happens before the shift, so col_out is the K-1 rows above the incoming pixel.
  always_comb begin
    col_out = '0;
    for (int j = 0; j < ROWS; j++)
      col_out[j*PIX_W +: PIX_W] = mem[j][col];
  end

endmodule

// File: rtl/im2col_stream.sv
// Streaming im2col window generator: raster pixels in, flattened KxK x CH windows out.
// Optional IM2COL_STALL_CNT_EN adds stall_cnt_o, a saturating count of output stall cycles.
module im2col_stream
  import cnn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [CH*DATA_W-1:0]       pix_i,
  input  logic                       vld_i,
  output logic                       rdy_o,
  output logic [K*K*CH*DATA_W-1:0]   win_o,
  output logic                       vld_o,
  input  logic                       rdy_i,
  output logic                       last_o,
  output logic                       frame_done_o
`ifdef IM2COL_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt_o
`endif
);

  localparam int PIX_W = CH * DATA_W;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int OW    = out_dim(IMG_W, K, STRIDE);
  localparam int OH    = out_dim(IMG_H, K, STRIDE);

  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_K    = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST = CW'((OW - 1) * STRIDE + K - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'((OH - 1) * STRIDE + K - 1);
  localparam logic [SW-1:0] PH_MAX   = SW'(STRIDE - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] col_ph, row_ph;
  logic          take, emit, at_last;

  logic [(K-1)*PIX_W-1:0]   lb_col;
  logic [PIX_W-1:0]         win_p0 [K][K];
  logic [PIX_W-1:0]         win_nx [K][K];
  logic [K*K*PIX_W-1:0]     win_flat;

  assign rdy_o   = !vld_o || rdy_i;
  assign take    = vld_i && rdy_o && !clear;
  // col_ph/row_ph track (pos-(K-1)) mod STRIDE once past the border, avoiding a divider.
  assign emit    = take && (col >= COL_K) && (row >= ROW_K) && (col_ph == '0) && (row_ph == '0);
  assign at_last = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (clear) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (take) begin
      if (col == COL_MAX) begin
        col    <= '0;
        col_ph <= '0;
        if (row == ROW_MAX) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row <= row + RW'(1);
          if (row >= ROW_K)
            row_ph <= (row_ph == PH_MAX) ? '0 : row_ph + SW'(1);
        end
      end else begin
        col <= col + CW'(1);
        if (col >= COL_K)
          col_ph <= (col_ph == PH_MAX) ? '0 : col_ph + SW'(1);
      end
    end
  end

  im2col_line_buf #(
    .PIX_W (PIX_W),
    .ROWS  (K - 1),
    .IMG_W (IMG_W),
    .CW    (CW)
  ) u_line_buf (
    .clk      (clk),
    .reset    (reset),
    .shift_en (take),
    .col      (col),
    .pix_in   (pix_i),
    .col_out  (lb_col)
  );

  // Stage p0: window shifts left, new rightmost column = buffered rows + incoming pixel
  always_comb begin
    win_nx = win_p0;
    for (int m = 0; m < K; m++)
      for (int n = 0; n < K-1; n++)
        win_nx[m][n] = win_p0[m][n+1];
    for (int m = 0; m < K-1; m++)
      win_nx[m][K-1] = lb_col[m*PIX_W +: PIX_W];
    win_nx[K-1][K-1] = pix_i;
  end

  always_comb begin
    win_flat = '0;
    for (int m = 0; m < K; m++)
      for (int n = 0; n < K; n++)
        win_flat[tap_idx(m, n, K)*PIX_W +: PIX_W] = win_nx[m][n];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < K; m++)
        for (int n = 0; n < K; n++)
          win_p0[m][n] <= '0;
    end else if (take) begin
      win_p0 <= win_nx;
    end
  end

  // Output slot: a new window may overwrite the slot in the same cycle it drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_o        <= 1'b0;
      last_o       <= 1'b0;
      frame_done_o <= 1'b0;
      win_o        <= '0;
    end else begin
      frame_done_o <= !clear && vld_o && rdy_i && last_o;
      if (clear) begin
        vld_o  <= 1'b0;
        last_o <= 1'b0;
      end else if (emit) begin
        vld_o  <= 1'b1;
        last_o <= at_last;
        win_o  <= win_flat;
      end else if (rdy_i) begin
        vld_o  <= 1'b0;
        last_o <= 1'b0;
      end
    end
  end

`ifdef IM2COL_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_o <= '0;
    else if (clear)
      stall_cnt_o <= '0;
    else if (vld_o && !rdy_i && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_im2col_stream.sv
// Directed bench for im2col_stream: default 28x28 K=3 instance plus stride-2 8x8
// and 3-channel instances, checked against a reference image model.
module tb_im2col_stream;
  import cnn_pkg::*;

  localparam int W  = 28;
  localparam int NW = 676;
  localparam int NP = 784;
  localparam int OW = 26;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  pix_t pix_i = '0;
  logic vld_i = 1'b0, rdy_i = 1'b0;
  logic rdy_o, vld_o, last_o, frame_done_o;
  logic [71:0] win_o;

  logic [7:0]   pix2 = '0;
  logic         vld2 = 1'b0, rdy2 = 1'b1;
  logic         rdy_o2, vo2, last2, fd2;
  logic [71:0]  win2;

  logic [23:0]  pix3 = '0;
  logic         vld3 = 1'b0, rdy3 = 1'b0;
  logic         rdy_o3, vo3, last3, fd3;
  logic [215:0] win3;

`ifdef IM2COL_STALL_CNT_EN
  logic [31:0] stall_cnt_o, stall2, stall3;
`endif

  int total = 0, bad = 0;
  int p = 0, w = 0, gen_f = 0, chk_f = 0, nwin = 0, nfd = 0, nstall = 0;
  bit fd_exp = 1'b0, stall_prev = 1'b0;
  logic [71:0] held = '0;

  always #5 clk = ~clk;

  im2col_stream dut (
    .clk(clk), .reset(reset), .clear(clear), .pix_i(pix_i), .vld_i(vld_i), .rdy_o(rdy_o),
    .win_o(win_o), .vld_o(vld_o), .rdy_i(rdy_i), .last_o(last_o), .frame_done_o(frame_done_o)
`ifdef IM2COL_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  im2col_stream #(.IMG_W(8), .IMG_H(8), .STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .clear(1'b0), .pix_i(pix2), .vld_i(vld2), .rdy_o(rdy_o2),
    .win_o(win2), .vld_o(vo2), .rdy_i(rdy2), .last_o(last2), .frame_done_o(fd2)
`ifdef IM2COL_STALL_CNT_EN
    , .stall_cnt_o(stall2)
`endif
  );

  im2col_stream #(.CH(3)) dut3 (
    .clk(clk), .reset(reset), .clear(1'b0), .pix_i(pix3), .vld_i(vld3), .rdy_o(rdy_o3),
    .win_o(win3), .vld_o(vo3), .rdy_i(rdy3), .last_o(last3), .frame_done_o(fd3)
`ifdef IM2COL_STALL_CNT_EN
    , .stall_cnt_o(stall3)
`endif
  );

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ofs(input int f);
    return (f * 37) % 256;
  endfunction

  // Reference window: image[tr+m][tc+n], channel c = pixel + 64*c.
  function automatic logic [215:0] mwin(input int iw, input int ch, input int tr, input int tc, input int off);
    logic [215:0] r;
    int v;
    r = '0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++)
        for (int c = 0; c < ch; c++) begin
          v = ((tr + m) * iw + tc + n + off + c * 64) % 256;
          r[((m * 3 + n) * ch + c) * 8 +: 8] = 8'(v);
        end
    return r;
  endfunction

  // One clock of the main instance; entered and left at posedge+1.
  task automatic tick(input bit rv, input bit rr, input bit clr);
    vld_i = rv;
    rdy_i = rr;
    clear = clr;
    pix_i = pix_t'((p + ofs(gen_f)) % 256);
    @(negedge clk);
    if (stall_prev) chk("hold", {vld_o, win_o}, {1'b1, held});
    chk("frame_done", frame_done_o, fd_exp);
    if (frame_done_o) nfd++;
    fd_exp = 1'b0;
    if (vld_o && rdy_i) begin
      chk("window", win_o, mwin(W, 1, w / OW, w % OW, ofs(chk_f)));
      chk("last", last_o, w == NW - 1);
      fd_exp = (w == NW - 1) && !clr;
      nwin++;
      w++;
      if (w == NW) begin
        w = 0;
        chk_f++;
      end
    end
    stall_prev = vld_o && !rdy_i && !clr;
    held = win_o;
    if (stall_prev) nstall++;
    if (rv && rdy_o && !clr) begin
      p++;
      if (p == NP) begin
        p = 0;
        gen_f++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sb_restart();
    gen_f++;
    chk_f = gen_f;
    p = 0;
    w = 0;
    fd_exp = 1'b0;
    stall_prev = 1'b0;
    nstall = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, f0, w2, p2, fs;
    logic [7:0] t3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", rdy_o, 1'b1);
    chk("rst_vld", vld_o, 1'b0);
    chk("rst_last", last_o, 1'b0);
    chk("rst_fd", frame_done_o, 1'b0);
    chk("rst_win", win_o, '0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Stride 2 on 8x8: 9 windows at even top-left positions
    w2 = 0;
    p2 = 0;
    for (int i = 0; i < 80; i++) begin
      vld2 = (p2 < 64);
      pix2 = 8'(p2);
      @(negedge clk);
      if (vo2) begin
        chk("s2_window", win2, mwin(8, 1, (w2 / 3) * 2, (w2 % 3) * 2, 0));
        chk("s2_last", last2, w2 == 8);
        w2++;
      end
      if (vld2 && rdy_o2) p2++;
      @(posedge clk);
      #1;
    end
    vld2 = 1'b0;
    chk("s2_count", w2, 9);

    // Three channels: first window, tap 4 channel 2 = 29 + 128
    for (int i = 0; i < 59; i++) begin
      vld3 = 1'b1;
      pix3 = {8'((i + 128) % 256), 8'((i + 64) % 256), 8'(i % 256)};
      @(posedge clk);
      #1;
    end
    vld3 = 1'b0;
    @(negedge clk);
    chk("c3_vld", vo3, 1'b1);
    t3 = win3[(4 * 3 + 2) * 8 +: 8];
    chk("c3_tap4_ch2", t3, 8'd157);
    chk("c3_window", win3, mwin(W, 3, 0, 0, 0));
    @(posedge clk);
    #1;

    // Full frame, continuous flow
    repeat (NP) tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    chk("t1_windows", nwin, NW);
    chk("t1_done", nfd, 1);

    // Random input gaps and downstream backpressure
    n0 = nwin;
    f0 = nfd;
    for (int i = 0; i < 8000 && gen_f < 2; i++)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0);
    for (int i = 0; i < 200 && chk_f < 2; i++) tick(1'b0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b1, 1'b0);
    chk("t3_windows", nwin - n0, NW);
    chk("t3_done", nfd - f0, 1);

    // Clear at pixel 300, then a fresh frame
    for (int i = 0; i < 400 && p < 300; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    sb_restart();
    #1;
    chk("clr_vld", vld_o, 1'b0);
    chk("clr_last", last_o, 1'b0);
    n0 = nwin;
    f0 = nfd;
    repeat (NP) tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    chk("clr_windows", nwin - n0, NW);
    chk("clr_done", nfd - f0, 1);

    // Reset mid-frame, then a fresh frame
    for (int i = 0; i < 400 && p < 300; i++) tick(1'b1, 1'b1, 1'b0);
    vld_i = 1'b0;
    reset = 1'b0;
    #2;
    chk("mrst_vld", vld_o, 1'b0);
    chk("mrst_last", last_o, 1'b0);
    chk("mrst_fd", frame_done_o, 1'b0);
    chk("mrst_win", win_o, '0);
    chk("mrst_rdy", rdy_o, 1'b1);
    @(posedge clk);
    #1;
    chk("mrst_win_held", win_o, '0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    sb_restart();
    n0 = nwin;
    f0 = nfd;
    repeat (NP) tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    chk("mrst_windows", nwin - n0, NW);
    chk("mrst_done", nfd - f0, 1);

    // Two back-to-back frames with occasional stalls
    n0 = nwin;
    f0 = nfd;
    fs = gen_f;
    for (int i = 0; i < 4000 && gen_f < fs + 2; i++)
      tick(1'b1, $urandom_range(0, 7) != 0, 1'b0);
    for (int i = 0; i < 200 && chk_f < fs + 2; i++) tick(1'b0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b1, 1'b0);
    chk("b2b_windows", nwin - n0, 2 * NW);
    chk("b2b_done", nfd - f0, 2);
`ifdef IM2COL_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, nstall);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
